uart_top: RTL and testbench
===========================

Name: uart_top

Overview:
- Full-duplex UART with a 16-entry TX FIFO, a 16-entry RX FIFO, a programmable 16x-oversampling baud generator, and configurable frame format.
- Sits behind a simple register-style host interface: config, baud, write data, read data, status.
- Host pushes bytes with uart_write and pops received bytes with uart_read.

Parameters:
- TX_FIFO_DEPTH, 16, TX FIFO entries; power of 2.
- RX_FIFO_DEPTH, 16, RX FIFO entries; power of 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  serial input; idle high; synchronised with a 2-flop synchroniser.
- uart_config  in  16  frame and feature configuration; see Behaviour.
- uart_baudgen  in  16  oversample divisor; one tick every uart_baudgen clocks.
- uart_data_write  in  16  TX data; bits [7:0] are used.
- uart_write  in  1  one-cycle push strobe into the TX FIFO.
- uart_read  in  1  per-cycle pop enable for the RX FIFO.
- uart_en  in  1  global enable for baud generator, TX and RX.
- tx  out  1  serial output; idle high.
- uart_status  out  16  status flags.
- uart_data_read  out  16  last popped RX entry.

Behaviour:
- Reset values:
  - tx=1, uart_status=16'h0005 (both FIFOs empty), uart_data_read=0.
  - FIFOs cleared, FSMs IDLE, baud counter 0.
- uart_config fields:
  - [0] tx_en; [1] rx_en.
  - [3:2] data bits: 00=5, 01=6, 10=7, 11=8.
  - [4] stop bits: 0=1, 1=2.
  - [5] parity enable; [6] parity odd(1)/even(0).
  - [7] loopback (see Optional Feature).
  - [11:8] RX threshold; [15:12] reserved.
- Config is sampled at each frame start; mid-frame changes apply to the next frame.
- Baud generator:
  - Counts 0..uart_baudgen-1 and emits a 1-clock tick at the wrap.
  - uart_baudgen=0 produces no ticks.
  - Counter held at 0 while uart_en=0.
  - 16 ticks per bit. Example: 50 MHz clock, uart_baudgen=27 gives 432 clocks per bit (~115.7 kbaud).
- Write path:
  - uart_write=1 with TX FIFO not full pushes uart_data_write[7:0].
  - A write while full is dropped; no state change.
  - Writes are accepted regardless of uart_en.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - Leaves IDLE when uart_en & tx_en & FIFO not empty: pops the head and drives the start bit from the next clock.
  - Each bit lasts 16 ticks; data goes LSB first.
  - Parity bit is present only if enabled.
  - After the stop bit(s) returns to IDLE; the next byte starts back-to-back.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - A falling edge on the synchronised rx with uart_en & rx_en enters START.
  - At tick 8: rx still 0 proceeds; otherwise false start, back to IDLE.
  - Data, parity and stop are sampled at tick 16 of each bit (bit centre).
  - Stop sampled 0 sets frame error; parity mismatch sets parity error.
  - At end of frame, {frame_err, parity_err, data zero-extended to 8} is pushed into the RX FIFO (10 bits).
  - If the RX FIFO is full, the entry is dropped and overrun is set.
- Read path:
  - Each clock with uart_read=1 and RX FIFO not empty pops one entry.
  - On the next edge, uart_data_read is loaded with {6'b0, frame_err, parity_err, data[7:0]} and holds until the next pop.
  - uart_read held high drains each byte 1 cycle after arrival.
  - Pop on empty: no effect.
- Simultaneous push and pop on the same FIFO in one cycle are both performed; the count is unchanged. A push while full is dropped even with a simultaneous pop (pop has no bypass).
- uart_status bits:
  - [0] tx_empty; [1] tx_full; [2] rx_empty; [3] rx_full.
  - [4] tx_busy (TX FSM not IDLE).
  - [5] parity_err sticky; [6] frame_err sticky; [7] overrun sticky.
  - [8] rx_count >= cfg[11:8].
  - [15:9]=0.
  - Sticky bits clear only on reset or while uart_en=0.
- uart_en=0:
  - Both FSMs return to IDLE and tx=1 on the next clock.
  - Baud counter held; FIFO contents retained.
- Reset asserted mid-frame aborts immediately: tx=1, all FIFOs emptied.

Optional Feature:
- Macro UART_LOOPBACK_EN.
- Defined: when uart_config[7]=1, the RX path takes the internal TX serial stream instead of rx, and the tx pin is held at 1.
- Not defined: uart_config[7] is ignored and RX always uses rx.

Test Plan:
- Reset low: tx=1, uart_status=16'h0005, uart_data_read=0; hold, then release.
- Baud 27, config 16'h096f (8 data, odd parity, 1 stop), tx externally looped to rx, write 8'h61:
  - tx low for 432 clocks.
  - 11-bit frame spans 4752 clocks.
  - Parity bit=0.
  - uart_data_read=16'h0061 after the pop, no error bits.
- Push 16 bytes (61,5c,da,e2,23,ad,ff,55,aa,...) before uart_en: tx_full=1, a 17th write is dropped, then all 16 are received in order.
- uart_read held low with 17+ frames received: rx_full=1, overrun=1, and status[8]=1 once 9 bytes are queued.
- Force rx low at the stop position: frame_err sticky set and entry bit9=1. Even-parity config with an odd-parity frame: parity_err set and bit8=1.
- Drop uart_en mid-frame: tx returns to 1 the next clock, tx_busy=0, FIFO contents kept. Reassert uart_en: transmission resumes with the next FIFO byte.

Source files
------------

// File: rtl/uart_top.sv
// Full-duplex UART: 16x oversampling baud generator, TX/RX FIFOs, configurable frame format.
// Optional feature: define UART_LOOPBACK_EN so that uart_config[7] feeds the TX stream into RX.
module uart_top #(
  parameter int unsigned TX_FIFO_DEPTH = 16,
  parameter int unsigned RX_FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [15:0] uart_config,
  input  logic [15:0] uart_baudgen,
  input  logic [15:0] uart_data_write,
  input  logic        uart_write,
  input  logic        uart_read,
  input  logic        uart_en,
  output logic        tx,
  output logic [15:0] uart_status,
  output logic [15:0] uart_data_read
);
  localparam int unsigned TxAw = $clog2(TX_FIFO_DEPTH);
  localparam int unsigned RxAw = $clog2(RX_FIFO_DEPTH);
  localparam logic [TxAw:0] TxOne = 1;
  localparam logic [RxAw:0] RxOne = 1;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  // Baud generator; tick is registered so a frame started on enable gets full-length bits.
  logic [15:0] baud_cnt_q;
  logic        tick_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else if (!uart_en || uart_baudgen == 16'd0) begin
      baud_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else if (baud_cnt_q >= uart_baudgen - 16'd1) begin
      baud_cnt_q <= '0;
      tick_q     <= 1'b1;
    end else begin
      baud_cnt_q <= baud_cnt_q + 16'd1;
      tick_q     <= 1'b0;
    end
  end

  // TX FIFO
  logic [7:0]    tx_mem [TX_FIFO_DEPTH];
  logic [TxAw:0] tx_wr_q, tx_rd_q, tx_count;
  logic          tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]    tx_head;

  assign tx_count = tx_wr_q - tx_rd_q;
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TX_FIFO_DEPTH[TxAw:0]);
  assign tx_push  = uart_write & ~tx_full;
  assign tx_head  = tx_mem[tx_rd_q[TxAw-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + TxOne;
      if (tx_pop)  tx_rd_q <= tx_rd_q + TxOne;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[TxAw-1:0]] <= uart_data_write[7:0];
  end

  // TX FSM
  logic [2:0] tx_state_q, tx_state_d, tx_bit_q, tx_bit_d, tx_last_q, tx_last_d;
  logic [3:0] tx_tcnt_q, tx_tcnt_d;
  logic [7:0] tx_shift_q, tx_shift_d, tx_mask;
  logic       tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d, tx_stop2_q, tx_stop2_d;
  logic       tx_can_start, tx_load, tx_line;

  assign tx_mask      = 8'hff >> (2'd3 - uart_config[3:2]);
  assign tx_can_start = uart_config[0] & ~tx_empty;
  assign tx_pop       = tx_load;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_bit_d    = tx_bit_q;
    tx_last_d   = tx_last_q;
    tx_tcnt_d   = tx_tcnt_q;
    tx_shift_d  = tx_shift_q;
    tx_par_d    = tx_par_q;
    tx_par_en_d = tx_par_en_q;
    tx_stop2_d  = tx_stop2_q;
    tx_load     = 1'b0;
    if (!uart_en) begin
      tx_state_d = StIdle;
      tx_tcnt_d  = '0;
    end else if (tx_state_q == StIdle) begin
      tx_load = tx_can_start;
    end else if (tick_q) begin
      tx_tcnt_d = tx_tcnt_q + 4'd1;
      if (tx_tcnt_q == 4'd15) begin
        tx_bit_d = tx_bit_q + 3'd1;
        case (tx_state_q)
          StStart: begin
            tx_state_d = StData;
            tx_bit_d   = '0;
          end
          StData: begin
            tx_shift_d = tx_shift_q >> 1;
            if (tx_bit_q == tx_last_q) begin
              tx_state_d = tx_par_en_q ? StParity : StStop;
              tx_bit_d   = '0;
            end
          end
          StParity: begin
            tx_state_d = StStop;
            tx_bit_d   = '0;
          end
          default: begin
            // Chain straight into the next frame when more data is queued.
            if (!tx_stop2_q || tx_bit_q != 3'd0) begin
              tx_state_d = StIdle;
              tx_load    = tx_can_start;
            end
          end
        endcase
      end
    end
    if (tx_load) begin
      tx_state_d  = StStart;
      tx_tcnt_d   = '0;
      tx_bit_d    = '0;
      tx_shift_d  = tx_head;
      tx_last_d   = {1'b1, uart_config[3:2]};
      tx_par_d    = (^(tx_head & tx_mask)) ^ uart_config[6];
      tx_par_en_d = uart_config[5];
      tx_stop2_d  = uart_config[4];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q  <= StIdle;
      tx_bit_q    <= '0;
      tx_last_q   <= '0;
      tx_tcnt_q   <= '0;
      tx_shift_q  <= '0;
      tx_par_q    <= 1'b0;
      tx_par_en_q <= 1'b0;
      tx_stop2_q  <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_bit_q    <= tx_bit_d;
      tx_last_q   <= tx_last_d;
      tx_tcnt_q   <= tx_tcnt_d;
      tx_shift_q  <= tx_shift_d;
      tx_par_q    <= tx_par_d;
      tx_par_en_q <= tx_par_en_d;
      tx_stop2_q  <= tx_stop2_d;
    end
  end

  always_comb begin
    case (tx_state_q)
      StStart:  tx_line = 1'b0;
      StData:   tx_line = tx_shift_q[0];
      StParity: tx_line = tx_par_q;
      default:  tx_line = 1'b1;
    endcase
  end

  logic rx_src;
  logic unused;
`ifdef UART_LOOPBACK_EN
  assign rx_src = uart_config[7] ? tx_line : rx;
  assign tx     = uart_config[7] ? 1'b1 : tx_line;
  assign unused = ^{uart_data_write[15:8], uart_config[15:12]};
`else
  assign rx_src = rx;
  assign tx     = tx_line;
  assign unused = ^{uart_data_write[15:8], uart_config[15:12], uart_config[7]};
`endif

  // RX synchroniser and edge detect
  logic [1:0] rx_sync_q;
  logic       rx_prev_q, rx_s;

  assign rx_s = rx_sync_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx_src};
      rx_prev_q <= rx_s;
    end
  end

  // RX FSM
  logic [2:0] rx_state_q, rx_state_d, rx_bit_q, rx_bit_d, rx_last_q, rx_last_d;
  logic [3:0] rx_tcnt_q, rx_tcnt_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d, rx_perr_q, rx_perr_d;
  logic       rx_push, rx_frame_bad;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_bit_d     = rx_bit_q;
    rx_last_d    = rx_last_q;
    rx_tcnt_d    = rx_tcnt_q;
    rx_data_d    = rx_data_q;
    rx_par_en_d  = rx_par_en_q;
    rx_odd_d     = rx_odd_q;
    rx_perr_d    = rx_perr_q;
    rx_push      = 1'b0;
    rx_frame_bad = 1'b0;
    if (!uart_en) begin
      rx_state_d = StIdle;
      rx_tcnt_d  = '0;
    end else begin
      case (rx_state_q)
        StIdle: begin
          if (uart_config[1] && rx_prev_q && !rx_s) begin
            rx_state_d  = StStart;
            rx_tcnt_d   = '0;
            rx_bit_d    = '0;
            rx_data_d   = '0;
            rx_perr_d   = 1'b0;
            rx_last_d   = {1'b1, uart_config[3:2]};
            rx_par_en_d = uart_config[5];
            rx_odd_d    = uart_config[6];
          end
        end
        StStart: begin
          if (tick_q) begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
            if (rx_tcnt_q == 4'd7) begin
              rx_tcnt_d  = '0;
              rx_state_d = rx_s ? StIdle : StData;
            end
          end
        end
        default: begin
          if (tick_q) begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
            if (rx_tcnt_q == 4'd15) begin
              case (rx_state_q)
                StData: begin
                  rx_data_d[rx_bit_q] = rx_s;
                  rx_bit_d = rx_bit_q + 3'd1;
                  if (rx_bit_q == rx_last_q) rx_state_d = rx_par_en_q ? StParity : StStop;
                end
                StParity: begin
                  rx_perr_d  = rx_s ^ (^rx_data_q) ^ rx_odd_q;
                  rx_state_d = StStop;
                end
                default: begin
                  rx_push      = 1'b1;
                  rx_frame_bad = ~rx_s;
                  rx_state_d   = StIdle;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q  <= StIdle;
      rx_bit_q    <= '0;
      rx_last_q   <= '0;
      rx_tcnt_q   <= '0;
      rx_data_q   <= '0;
      rx_par_en_q <= 1'b0;
      rx_odd_q    <= 1'b0;
      rx_perr_q   <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_bit_q    <= rx_bit_d;
      rx_last_q   <= rx_last_d;
      rx_tcnt_q   <= rx_tcnt_d;
      rx_data_q   <= rx_data_d;
      rx_par_en_q <= rx_par_en_d;
      rx_odd_q    <= rx_odd_d;
      rx_perr_q   <= rx_perr_d;
    end
  end

  // RX FIFO: entry is {frame_err, parity_err, data}
  logic [9:0]    rx_mem [RX_FIFO_DEPTH];
  logic [RxAw:0] rx_wr_q, rx_rd_q, rx_count;
  logic          rx_empty, rx_full, rx_wr, rx_pop;
  logic [15:0]   data_read_q;

  assign rx_count = rx_wr_q - rx_rd_q;
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_FIFO_DEPTH[RxAw:0]);
  assign rx_wr    = rx_push & ~rx_full;
  assign rx_pop   = uart_read & ~rx_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      data_read_q <= '0;
    end else begin
      if (rx_wr) rx_wr_q <= rx_wr_q + RxOne;
      if (rx_pop) begin
        rx_rd_q     <= rx_rd_q + RxOne;
        data_read_q <= {6'd0, rx_mem[rx_rd_q[RxAw-1:0]]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wr_q[RxAw-1:0]] <= {rx_frame_bad, rx_perr_q, rx_data_q};
  end

  // Sticky error flags
  logic par_st_q, frm_st_q, ovr_st_q, thr_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_st_q <= 1'b0;
      frm_st_q <= 1'b0;
      ovr_st_q <= 1'b0;
    end else if (!uart_en) begin
      par_st_q <= 1'b0;
      frm_st_q <= 1'b0;
      ovr_st_q <= 1'b0;
    end else begin
      if (rx_push && rx_perr_q)    par_st_q <= 1'b1;
      if (rx_push && rx_frame_bad) frm_st_q <= 1'b1;
      if (rx_push && rx_full)      ovr_st_q <= 1'b1;
    end
  end

  // A zero threshold disables the level flag.
  assign thr_hit = (uart_config[11:8] != 4'd0) &&
                   (32'(rx_count) >= 32'(uart_config[11:8]));

  assign uart_status = {7'd0, thr_hit, ovr_st_q, frm_st_q, par_st_q, (tx_state_q != StIdle),
                        rx_full, rx_empty, tx_full, tx_empty};
  assign uart_data_read = data_read_q;

endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top: tx looped back to rx, with an optional forced-low override.
module tb_uart_top;
  logic        clk;
  logic        reset;
  logic        rx;
  logic [15:0] uart_config;
  logic [15:0] uart_baudgen;
  logic [15:0] uart_data_write;
  logic        uart_write;
  logic        uart_read;
  logic        uart_en;
  logic        tx;
  logic [15:0] uart_status;
  logic [15:0] uart_data_read;
  logic        rx_force;

  int n_total = 0;
  int n_bad   = 0;

  uart_top dut (
    .clk            (clk),
    .reset          (reset),
    .rx             (rx),
    .uart_config    (uart_config),
    .uart_baudgen   (uart_baudgen),
    .uart_data_write(uart_data_write),
    .uart_write     (uart_write),
    .uart_read      (uart_read),
    .uart_en        (uart_en),
    .tx             (tx),
    .uart_status    (uart_status),
    .uart_data_read (uart_data_read)
  );

  assign rx = rx_force ? 1'b0 : tx;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    uart_data_write = {8'h00, b};
    uart_write = 1'b1;
    @(negedge clk);
    uart_write = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp);
    @(negedge clk);
    uart_read = 1'b1;
    @(negedge clk);
    uart_read = 1'b0;
    check_val(tag, uart_data_read, exp);
  endtask

  logic [7:0] seq [16] = '{8'h61, 8'h5c, 8'hda, 8'he2, 8'h23, 8'had, 8'hff, 8'h55,
                           8'haa, 8'h01, 8'h80, 8'h7e, 8'h3c, 8'hc3, 8'h0f, 8'hf0};

  initial begin
    int low_cnt, busy_cnt;
    logic low_done, par_bit;
    clk = 1'b0;
    reset = 1'b1;
    rx_force = 1'b0;
    uart_config = 16'h0000;
    uart_baudgen = 16'h0000;
    uart_data_write = 16'h0000;
    uart_write = 1'b0;
    uart_read = 1'b0;
    uart_en = 1'b0;
    #2 reset = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("reset_tx", tx, 1);
    check_val("reset_status", uart_status, 16'h0005);
    check_val("reset_data_read", uart_data_read, 0);
    @(negedge clk);
    reset = 1'b1;

    // 8O1 at baud 27, single byte 0x61
    uart_baudgen = 16'd27;
    uart_config = 16'h096f;
    uart_read = 1'b1;
    write_byte(8'h61);
    @(negedge clk);
    uart_en = 1'b1;
    low_cnt = 0;
    busy_cnt = 0;
    low_done = 1'b0;
    par_bit = 1'b1;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (!low_done && tx == 1'b0) low_cnt++;
      else if (low_cnt != 0) low_done = 1'b1;
      if (k == 9 * 432 + 216) par_bit = tx;
      if (uart_status[4]) busy_cnt++;
    end
    check_val("start_bit_len", low_cnt, 432);
    check_val("frame_len", busy_cnt, 4752);
    check_val("parity_bit", par_bit, 0);
    check_val("rx_data_61", uart_data_read, 16'h0061);
    check_val("no_errors", uart_status[7:5], 0);
    check_val("rx_empty_after", uart_status[2], 1);

    // Fill TX FIFO, overflow RX FIFO, threshold 9
    @(negedge clk);
    uart_en = 1'b0;
    uart_baudgen = 16'd1;
    uart_config = 16'h090f;
    uart_read = 1'b0;
    for (int i = 0; i < 16; i++) write_byte(seq[i]);
    check_val("tx_full", uart_status[1], 1);
    check_val("tx_not_empty", uart_status[0], 0);
    write_byte(8'h77);
    check_val("tx_full_after_drop", uart_status[1], 1);
    @(negedge clk);
    uart_en = 1'b1;
    repeat (2700) @(negedge clk);
    check_val("rx_full", uart_status[3], 1);
    check_val("no_overrun_yet", uart_status[7], 0);
    check_val("thr_16", uart_status[8], 1);
    write_byte(8'h11);
    write_byte(8'h22);
    repeat (400) @(negedge clk);
    check_val("overrun", uart_status[7], 1);
    check_val("rx_full_still", uart_status[3], 1);
    for (int i = 0; i < 7; i++) pop_check("order", {8'h00, seq[i]});
    check_val("thr_9", uart_status[8], 1);
    pop_check("order", {8'h00, seq[7]});
    check_val("thr_8", uart_status[8], 0);
    for (int i = 8; i < 16; i++) pop_check("order", {8'h00, seq[i]});
    check_val("rx_drained", uart_status[2], 1);
    pop_check("pop_empty_noop", {8'h00, seq[15]});

    // Frame error: force rx low across the stop bit
    @(negedge clk);
    uart_en = 1'b0;
    @(negedge clk);
    check_val("sticky_clear", uart_status[7:5], 0);
    uart_config = 16'h000f;
    uart_read = 1'b1;
    write_byte(8'h55);
    @(negedge clk);
    uart_en = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 146) rx_force = 1'b1;
      if (k == 160) rx_force = 1'b0;
    end
    check_val("frame_err_entry", uart_data_read, 16'h0255);
    check_val("frame_err_sticky", uart_status[6], 1);
    check_val("frame_no_parity_err", uart_status[5], 0);

    // Parity error: TX frames with odd parity, RX expects even
    @(negedge clk);
    uart_en = 1'b0;
    uart_config = 16'h006f;
    write_byte(8'ha5);
    @(negedge clk);
    uart_en = 1'b1;
    @(negedge clk);
    uart_config = 16'h002f;
    repeat (300) @(negedge clk);
    check_val("parity_err_entry", uart_data_read, 16'h01a5);
    check_val("parity_err_sticky", uart_status[5], 1);
    check_val("parity_no_frame_err", uart_status[6], 0);

    // Drop uart_en mid-frame, then resume with the next byte
    @(negedge clk);
    uart_en = 1'b0;
    uart_config = 16'h000f;
    write_byte(8'h3c);
    write_byte(8'hc3);
    @(negedge clk);
    uart_en = 1'b1;
    repeat (41) @(negedge clk);
    check_val("tx_low_before_drop", tx, 0);
    uart_en = 1'b0;
    @(negedge clk);
    check_val("drop_tx_idle", tx, 1);
    check_val("drop_not_busy", uart_status[4], 0);
    check_val("drop_fifo_kept", uart_status[0], 0);
    check_val("drop_no_rx", uart_data_read, 16'h01a5);
    repeat (5) @(negedge clk);
    uart_en = 1'b1;
    repeat (300) @(negedge clk);
    check_val("resume_data", uart_data_read, 16'h00c3);
    check_val("resume_tx_empty", uart_status[0], 1);

    // Asynchronous reset mid-frame
    write_byte(8'h00);
    repeat (20) @(negedge clk);
    check_val("pre_reset_tx_low", tx, 0);
    #2 reset = 1'b0;
    #1;
    check_val("midreset_tx", tx, 1);
    check_val("midreset_status", uart_status, 16'h0005);
    check_val("midreset_data_read", uart_data_read, 0);
    @(negedge clk);
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
